// File: rtl/wb_mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mtimer
//  Purpose  : Wishbone classic slave providing a RISC-V style 64-bit machine
//             timer (mtime / mtimecmp) with a clock prescaler and a level
//             timer interrupt.
//  Ports    : wb_clk_i  - clock, all logic on the rising edge
//             wb_rst_i  - synchronous active-high reset
//             wb_adr_i  - byte address, bits [4:2] select the register
//             wb_dat_i  - write data
//             wb_sel_i  - byte lane enables for writes
//             wb_we_i   - 1 = write, 0 = read
//             wb_cyc_i  - bus cycle
//             wb_stb_i  - strobe
//             wb_dat_o  - registered read data, valid while wb_ack_o = 1
//             wb_ack_o  - registered acknowledge (one wait state)
//             irq_o     - registered level interrupt
//  Register map (wb_adr_i[4:2]):
//             0 MTIME_LO  (read latches mtime[63:32] into the hi shadow)
//             1 MTIME_HI  (read returns the hi shadow)
//             2 CMP_LO    3 CMP_HI
//             4 CTRL      bit0 EN, bit1 IRQ_EN
//             5 STATUS    bit0 PEND = (mtime >= mtimecmp), read-only
//             6,7 reserved: read 0, writes ignored
//  Revision : 1.0 - initial release
// ============================================================================
module wb_mtimer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    localparam int unsigned c_PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);

    localparam logic [2:0] c_A_MTIME_LO = 3'd0;
    localparam logic [2:0] c_A_MTIME_HI = 3'd1;
    localparam logic [2:0] c_A_CMP_LO   = 3'd2;
    localparam logic [2:0] c_A_CMP_HI   = 3'd3;
    localparam logic [2:0] c_A_CTRL     = 3'd4;
    localparam logic [2:0] c_A_STATUS   = 3'd5;

    logic [63:0]          r_mtime;
    logic [63:0]          r_cmp;
    logic                 r_en;
    logic                 r_irq_en;
    logic [31:0]          r_hi_shadow;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 r_irq;

    logic [2:0]  w_idx;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_pend;
    logic [31:0] w_rdata;
    logic        w_unused_adr;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_idx        = wb_adr_i[4:2];
    assign w_unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    // The "& ~r_ack" term forces ack low for a cycle after every access, so
    // each access is seen exactly once on the edge that raises ack.
    assign w_access = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_access & wb_we_i;
    assign w_rd     = w_access & ~wb_we_i;
    assign w_pend   = (r_mtime >= r_cmp);

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            c_A_MTIME_LO: w_rdata = r_mtime[31:0];
            c_A_MTIME_HI: w_rdata = r_hi_shadow;
            c_A_CMP_LO:   w_rdata = r_cmp[31:0];
            c_A_CMP_HI:   w_rdata = r_cmp[63:32];
            c_A_CTRL:     w_rdata = {30'd0, r_irq_en, r_en};
            c_A_STATUS:   w_rdata = {31'd0, w_pend};
            default:      w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mtime     <= 64'd0;
            r_cmp       <= CMP_RESET;
            r_en        <= 1'b0;
            r_irq_en    <= 1'b0;
            r_hi_shadow <= 32'd0;
            r_presc     <= '0;
            r_ack       <= 1'b0;
            r_dat       <= 32'd0;
            r_irq       <= 1'b0;
        end else begin
            r_ack <= w_access;
            r_irq <= r_irq_en & w_pend;

            // A software write to mtime takes priority over a prescaler tick
            // and restarts the prescaler so the next tick is a full period away.
            if (w_wr && (w_idx == c_A_MTIME_LO)) begin
                r_mtime[31:0] <= merge_lanes(r_mtime[31:0], wb_dat_i, wb_sel_i);
                r_presc       <= '0;
            end else if (w_wr && (w_idx == c_A_MTIME_HI)) begin
                r_mtime[63:32] <= merge_lanes(r_mtime[63:32], wb_dat_i, wb_sel_i);
                r_presc        <= '0;
            end else if (r_en) begin
                if (r_presc == c_PRESC_LAST) begin
                    r_presc <= '0;
                    r_mtime <= r_mtime + 64'd1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (w_wr) begin
                case (w_idx)
                    c_A_CMP_LO: r_cmp[31:0]  <= merge_lanes(r_cmp[31:0], wb_dat_i, wb_sel_i);
                    c_A_CMP_HI: r_cmp[63:32] <= merge_lanes(r_cmp[63:32], wb_dat_i, wb_sel_i);
                    c_A_CTRL: begin
                        if (wb_sel_i[0]) begin
                            r_en     <= wb_dat_i[0];
                            r_irq_en <= wb_dat_i[1];
                        end
                    end
                    default: ;
                endcase
            end

            // Reading LO snapshots HI so a LO-then-HI read pair is coherent
            // even when a carry occurs between the two accesses.
            if (w_rd) begin
                r_dat <= w_rdata;
                if (w_idx == c_A_MTIME_LO) begin
                    r_hi_shadow <= r_mtime[63:32];
                end
            end
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign irq_o    = r_irq;

endmodule
`default_nettype wire
